// File: rtl/coprocessor_debug_mem_arbiter.sv
// Coprocessor debug-RAM arbiter.
// Shares one single-port debug RAM between a JTAG debug slave (one-cycle
// command strobes buffered in a single pending slot) and an Avalon-MM host.
// One access is in flight at a time: IDLE grants, ACCESS drives the RAM,
// RDWAIT returns read data (RAM read latency is one cycle).
// Optional build macro COPROCESSOR_DBG_ARB_JTAG_PRIO_EN: when defined, JTAG
// always wins contention and the last-grant register is omitted; when
// undefined, contention is resolved round-robin (JTAG wins the first tie).
module coprocessor_debug_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // JTAG debug-slave side
  input  logic              jtag_req,
  input  logic              jtag_write,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic              jtag_busy,
  output logic              jtag_done,
  output logic [DATA_W-1:0] jtag_rdata,
  output logic              jtag_ovf,
  // Avalon-MM host side
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  // Shared RAM port
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // JTAG pending slot
  logic              slot_vld;
  logic              slot_write;
  logic [ADDR_W-1:0] slot_addr;
  logic [DATA_W-1:0] slot_wdata;

  // Latched attributes of the access in flight
  logic              gnt_host;
  logic              op_write;

  // Held read results between completions
  logic [DATA_W-1:0] jtag_rdata_q;
  logic [DATA_W-1:0] avs_rdata_q;

  logic host_req;
  logic pick_jtag;
  logic grant;
  logic done;
  logic slot_capture;

`ifndef COPROCESSOR_DBG_ARB_JTAG_PRIO_EN
  // 1 = the host received the most recent grant
  logic last_host;
`endif

  assign host_req = avs_read | avs_write;

  // Arbitration: choose JTAG or host for a grant issued in IDLE
  always_comb begin
    pick_jtag = 1'b0;
`ifdef COPROCESSOR_DBG_ARB_JTAG_PRIO_EN
    pick_jtag = slot_vld;
`else
    pick_jtag = slot_vld && (!host_req || last_host);
`endif
  end

  // Next-state logic and per-cycle grant/completion strobes
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (slot_vld || host_req) begin
          grant   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (op_write) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion outputs are decoded from the in-flight access so that reset
  // (which forces IDLE) suppresses them immediately.
  assign jtag_done       = done && !gnt_host;
  assign avs_waitrequest = !(done && gnt_host);
  assign jtag_busy       = slot_vld;

  // The slot frees in the jtag_done cycle, so a strobe in that cycle is taken.
  assign slot_capture = jtag_req && (!slot_vld || jtag_done);

  // Read data passes straight through in RDWAIT and is held afterwards.
  assign jtag_rdata   = (state_q == RDWAIT && !gnt_host) ? ram_rdata : jtag_rdata_q;
  assign avs_readdata = (state_q == RDWAIT &&  gnt_host) ? ram_rdata : avs_rdata_q;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pending-slot occupancy and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_vld <= 1'b0;
      jtag_ovf <= 1'b0;
    end else begin
      if (slot_capture) begin
        slot_vld <= 1'b1;
      end else if (jtag_done) begin
        slot_vld <= 1'b0;
      end
      if (jtag_req && !slot_capture) begin
        jtag_ovf <= 1'b1;
      end
    end
  end

  // Pending-slot payload; only meaningful while slot_vld is set
  always_ff @(posedge clk) begin
    if (slot_capture) begin
      slot_write <= jtag_write;
      slot_addr  <= jtag_addr;
      slot_wdata <= jtag_wdata;
    end
  end

  // Grant: latch requester, direction, address and data onto the RAM port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_host  <= 1'b0;
      op_write  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (grant) begin
        gnt_host <= !pick_jtag;
        if (pick_jtag) begin
          op_write  <= slot_write;
          ram_we    <= slot_write;
          ram_addr  <= slot_addr;
          ram_wdata <= slot_wdata;
        end else begin
          // read+write together is treated as a write
          op_write  <= avs_write;
          ram_we    <= avs_write;
          ram_addr  <= avs_address;
          ram_wdata <= avs_writedata;
        end
      end
    end
  end

`ifndef COPROCESSOR_DBG_ARB_JTAG_PRIO_EN
  // Round-robin history; resets to host so JTAG wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_host <= 1'b1;
    end else if (grant) begin
      last_host <= !pick_jtag;
    end
  end
`endif

  // Hold read results until the next read of the same requester completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jtag_rdata_q <= '0;
      avs_rdata_q  <= '0;
    end else if (state_q == RDWAIT) begin
      if (gnt_host) begin
        avs_rdata_q <= ram_rdata;
      end else begin
        jtag_rdata_q <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_coprocessor_debug_mem_arbiter.sv
// Scoreboard testbench for coprocessor_debug_mem_arbiter.
module tb_coprocessor_debug_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          jtag_req = 1'b0;
  logic          jtag_write = 1'b0;
  logic [AW-1:0] jtag_addr = '0;
  logic [DW-1:0] jtag_wdata = '0;
  logic          jtag_busy;
  logic          jtag_done;
  logic [DW-1:0] jtag_rdata;
  logic          jtag_ovf;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [AW-1:0] avs_address = '0;
  logic [DW-1:0] avs_writedata = '0;
  logic [DW-1:0] avs_readdata;
  logic          avs_waitrequest;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;

  coprocessor_debug_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .jtag_req(jtag_req), .jtag_write(jtag_write), .jtag_addr(jtag_addr),
    .jtag_wdata(jtag_wdata), .jtag_busy(jtag_busy), .jtag_done(jtag_done),
    .jtag_rdata(jtag_rdata), .jtag_ovf(jtag_ovf),
    .avs_read(avs_read), .avs_write(avs_write), .avs_address(avs_address),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Environment RAM: synchronous single port, one-cycle read latency
  logic [DW-1:0] ram_mem [256];
  logic          ram_clr = 1'b1;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
      ram_rdata <= '0;
    end else begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Reference model: memory contents plus expected completion sequence
  typedef struct packed {
    bit            is_host;
    bit            is_read;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [256];
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic handle_completion(input bit is_host);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_completion: got source %0d expected none at %0t", is_host, $time);
    end else begin
      checks--;
      e = exp_q.pop_front();
      chk("completion_source", 64'(is_host), 64'(e.is_host));
      if (e.is_read) begin
        if (is_host) chk("avs_readdata", 64'(avs_readdata), 64'(e.data));
        else         chk("jtag_rdata", 64'(jtag_rdata), 64'(e.data));
      end
    end
  endtask

  // Monitor: pop and compare on every completion the DUT presents
  always @(negedge clk) begin
    if (!reset) begin
      if (jtag_done) handle_completion(1'b0);
      if (!avs_waitrequest && (avs_read || avs_write)) handle_completion(1'b1);
    end
  end

  task automatic push_jtag(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (wr) begin
      model_mem[a] = d;
      exp_q.push_back('{is_host: 1'b0, is_read: 1'b0, data: d});
    end else begin
      exp_q.push_back('{is_host: 1'b0, is_read: 1'b1, data: model_mem[a]});
    end
  endtask

  task automatic push_host(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (wr) begin
      model_mem[a] = d;
      exp_q.push_back('{is_host: 1'b1, is_read: 1'b0, data: d});
    end else if (rd) begin
      exp_q.push_back('{is_host: 1'b1, is_read: 1'b1, data: model_mem[a]});
    end
  endtask

  // Pulse one JTAG strobe; returns one cycle later
  task automatic jtag_issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit push);
    if (push) push_jtag(wr, a, d);
    jtag_write = wr; jtag_addr = a; jtag_wdata = d; jtag_req = 1'b1;
    @(posedge clk); #1;
    jtag_req = 1'b0;
  endtask

  // Bounded wait until jtag_done is visible (sampled after the edge)
  task automatic wait_jtag_done(input string name);
    int n = 0;
    while (!jtag_done && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (!jtag_done) begin
      failures++; checks++;
      $display("FAIL %s_timeout: got no jtag_done expected one within 30 cycles", name);
    end
  endtask

  // Full Avalon transfer: hold request until waitrequest drops
  task automatic host_xfer(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit push);
    int n = 0;
    if (push) push_host(rd, wr, a, d);
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d;
    @(negedge clk);
    while (avs_waitrequest && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (avs_waitrequest) begin
      failures++; checks++;
      $display("FAIL host_timeout: got waitrequest=1 expected 0 within 30 cycles");
    end
    @(posedge clk); #1;
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #60000;
    $display("FAIL watchdog: got no finish expected finish before 60000ns");
    $fatal(1, "watchdog");
  end

`ifdef COPROCESSOR_DBG_ARB_JTAG_PRIO_EN
  localparam int NJ = 4;
`else
  localparam int NJ = 2;
`endif

  logic [DW-1:0] jd [4];
  logic [DW-1:0] hd [2];
  logic [DW-1:0] d_a;
  logic [DW-1:0] d_b;
  logic [DW-1:0] jr_val;

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    idle_cycles(3);

    // Reset state
    chk("rst_waitrequest", 64'(avs_waitrequest), 64'd1);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_jtag_busy", 64'(jtag_busy), 64'd0);
    chk("rst_jtag_done", 64'(jtag_done), 64'd0);
    chk("rst_jtag_ovf", 64'(jtag_ovf), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    chk("rst_jtag_rdata", 64'(jtag_rdata), 64'd0);
    chk("rst_avs_readdata", 64'(avs_readdata), 64'd0);
    reset = 1'b0; ram_clr = 1'b0;
    idle_cycles(2);

    // Contention straight after reset; JTAG re-strobes in each done cycle
    for (int k = 0; k < 4; k++) jd[k] = $urandom;
    for (int k = 0; k < 2; k++) hd[k] = $urandom;
`ifdef COPROCESSOR_DBG_ARB_JTAG_PRIO_EN
    for (int k = 0; k < 4; k++) push_jtag(1'b1, 8'(8'h20 + k), jd[k]);
    for (int k = 0; k < 2; k++) push_host(1'b0, 1'b1, 8'(8'h30 + k), hd[k]);
`else
    for (int k = 0; k < 2; k++) begin
      push_jtag(1'b1, 8'(8'h20 + k), jd[k]);
      push_host(1'b0, 1'b1, 8'(8'h30 + k), hd[k]);
    end
`endif
    fork
      begin
        for (int k = 0; k < NJ; k++) begin
          if (k > 0) wait_jtag_done("contention_jtag");
          jtag_issue(1'b1, 8'(8'h20 + k), jd[k], 1'b0);
        end
        wait_jtag_done("contention_jtag_last");
        @(posedge clk); #1;
      end
      begin
        @(posedge clk); #1;
        host_xfer(1'b0, 1'b1, 8'h30, hd[0], 1'b0);
        host_xfer(1'b0, 1'b1, 8'h31, hd[1], 1'b0);
      end
    join
    idle_cycles(3);
    chk("contention_drained", 64'(exp_q.size()), 64'd0);

    // Directed JTAG write 0x10 <- DEADBEEF
    jtag_issue(1'b1, 8'h10, 32'hDEADBEEF, 1'b1);
    chk("jw_busy_after_capture", 64'(jtag_busy), 64'd1);
    chk("jw_we_in_grant", 64'(ram_we), 64'd0);
    @(posedge clk); #1;
    chk("jw_ram_we", 64'(ram_we), 64'd1);
    chk("jw_ram_addr", 64'(ram_addr), 64'h10);
    chk("jw_ram_wdata", 64'(ram_wdata), 64'hDEADBEEF);
    chk("jw_done", 64'(jtag_done), 64'd1);
    @(posedge clk); #1;
    chk("jw_we_after", 64'(ram_we), 64'd0);
    chk("jw_busy_after", 64'(jtag_busy), 64'd0);
    chk("jw_done_one_cycle", 64'(jtag_done), 64'd0);

    // Directed host read 0x10: completes two cycles after grant
    push_host(1'b1, 1'b0, 8'h10, '0);
    avs_read = 1'b1; avs_address = 8'h10;
    #1 chk("hr_wait_grant", 64'(avs_waitrequest), 64'd1);
    @(posedge clk); #1;
    chk("hr_wait_access", 64'(avs_waitrequest), 64'd1);
    chk("hr_we_read", 64'(ram_we), 64'd0);
    @(posedge clk); #1;
    chk("hr_wait_done", 64'(avs_waitrequest), 64'd0);
    chk("hr_readdata", 64'(avs_readdata), 64'hDEADBEEF);
    @(posedge clk); #1;
    avs_read = 1'b0;
    idle_cycles(2);

    // Randomized serialized traffic against the model
    for (int i = 0; i < 40; i++) begin
      int       kind;
      bit       rd;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      kind = $urandom_range(0, 3);
      a = 8'($urandom_range(0, 15));
      d = $urandom;
      case (kind)
        0, 1: begin
          jtag_issue(kind == 0, a, d, 1'b1);
          wait_jtag_done("rand_jtag");
          @(posedge clk); #1;
        end
        2: host_xfer(1'b1, 1'b0, a, d, 1'b1);
        default: begin
          rd = 1'($urandom_range(0, 1));
          host_xfer(rd, 1'b1, a, d, 1'b1);
        end
      endcase
      idle_cycles($urandom_range(0, 2));
    end

    // jtag_rdata holds across other traffic
    jr_val = model_mem[8'h10];
    jtag_issue(1'b0, 8'h10, '0, 1'b1);
    wait_jtag_done("hold_read");
    @(posedge clk); #1;
    host_xfer(1'b0, 1'b1, 8'h11, 32'h1234_5678, 1'b1);
    jtag_issue(1'b1, 8'h12, 32'h0BAD_F00D, 1'b1);
    wait_jtag_done("hold_write");
    @(posedge clk); #1;
    chk("jtag_rdata_hold", 64'(jtag_rdata), 64'(jr_val));
    chk("ovf_clear_before_drop", 64'(jtag_ovf), 64'd0);

    // Second strobe while the first is pending is dropped
    d_a = $urandom; d_b = $urandom;
    jtag_issue(1'b1, 8'h40, d_a, 1'b1);
    jtag_issue(1'b1, 8'h41, d_b, 1'b0);
    idle_cycles(4);
    chk("ovf_set", 64'(jtag_ovf), 64'd1);
    chk("ovf_busy_clear", 64'(jtag_busy), 64'd0);
    chk("ovf_one_done", 64'(exp_q.size()), 64'd0);
    host_xfer(1'b1, 1'b0, 8'h41, '0, 1'b1);
    host_xfer(1'b1, 1'b0, 8'h40, '0, 1'b1);
    idle_cycles(2);

    // Reset during RDWAIT of a host read
    avs_read = 1'b1; avs_address = 8'h40;
    @(posedge clk); #1;
    chk("rr_wait_access", 64'(avs_waitrequest), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rr_waitrequest", 64'(avs_waitrequest), 64'd1);
    chk("rr_ram_we", 64'(ram_we), 64'd0);
    chk("rr_jtag_done", 64'(jtag_done), 64'd0);
    chk("rr_ovf_cleared", 64'(jtag_ovf), 64'd0);
    chk("rr_avs_readdata", 64'(avs_readdata), 64'd0);
    chk("rr_ram_addr", 64'(ram_addr), 64'd0);
    avs_read = 1'b0;
    @(posedge clk); #1;
    chk("rr_still_idle_wait", 64'(avs_waitrequest), 64'd1);
    reset = 1'b0;
    idle_cycles(3);
    chk("rr_no_we_after", 64'(ram_we), 64'd0);
    host_xfer(1'b1, 1'b0, 8'h40, '0, 1'b1);
    idle_cycles(3);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coprocessor_debug_mem_arbiter.md
COPROCESSOR_DEBUG_MEM_ARBITER -- requirements
Module: coprocessor_debug_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the debug-RAM word address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Ports (name / direction / width / meaning):
  - clk  in  1  sole clock.
  - reset  in  1  asynchronous, active-high.
  - jtag_req  in  1  one-cycle command strobe from the debug-slave sysclk side.
  - jtag_write  in  1  1 = write, 0 = read; qualified by jtag_req.
  - jtag_addr  in  ADDR_W  JTAG word address.
  - jtag_wdata  in  DATA_W  JTAG write data.
  - jtag_busy  out  1  a JTAG command is pending or in progress.
  - jtag_done  out  1  one-cycle completion pulse.
  - jtag_rdata  out  DATA_W  read result; valid with jtag_done.
  - jtag_ovf  out  1  sticky flag: a strobe was dropped.
  - avs_read, avs_write  in  1 each  Avalon-MM host requests.
  - avs_address  in  ADDR_W  host address.
  - avs_writedata  in  DATA_W  host write data.
  - avs_readdata  out  DATA_W  host read data.
  - avs_waitrequest  out  1  Avalon stall.
  - ram_addr  out  ADDR_W  shared RAM address.
  - ram_wdata  out  DATA_W  shared RAM write data.
  - ram_we  out  1  shared RAM write enable.
  - ram_rdata  in  DATA_W  RAM read data, 1-cycle latency.

Function
REQ-005 SHALL capture jtag_req, jtag_write, jtag_addr and jtag_wdata into a single pending slot when the slot is free.
REQ-006 SHALL drop a jtag_req arriving while the slot is occupied and set jtag_ovf, which stays set until reset.
REQ-007 SHALL accept a jtag_req arriving in the cycle jtag_done is asserted, because the slot frees in that cycle.
REQ-008 SHALL treat the host as requesting whenever avs_read or avs_write is high.
REQ-009 SHALL treat avs_read and avs_write both high as a write.
REQ-010 SHALL implement the FSM IDLE -> ACCESS -> (write: IDLE | read: RDWAIT -> IDLE).
REQ-011 In IDLE, SHALL grant a requester and latch its address, data and direction.
REQ-012 In ACCESS, SHALL drive ram_addr and ram_wdata, and assert ram_we for writes only.
REQ-013 In RDWAIT, SHALL capture ram_rdata into the granted requester's read-data output.
REQ-014 Write latency SHALL be: grant in cycle n, write and completion in cycle n+1.
REQ-015 Read latency SHALL be: grant in cycle n, read data valid and completion in cycle n+2.
REQ-016 On host completion, SHALL drive avs_waitrequest low for exactly one cycle.
REQ-017 avs_waitrequest SHALL otherwise be high while the host requests.
REQ-018 avs_readdata SHALL be valid in the host's read-completion cycle.
REQ-019 jtag_done SHALL pulse for one cycle on JTAG completion.
REQ-020 jtag_rdata SHALL hold its value until the next JTAG read completes.
REQ-021 When both requesters contend in IDLE, SHALL grant the one not granted last (round-robin).
REQ-022 The last-grant register SHALL reset to "host", so JTAG wins the first tie.
REQ-023 SHALL never grant a new requester outside IDLE: one access in flight, back-to-back grants separated by at least one IDLE cycle.
REQ-024 jtag_busy SHALL be high from the cycle after capture through the jtag_done cycle.
REQ-025 ram_we SHALL be low outside ACCESS.
REQ-026 Host request signals changing mid-transaction are protocol violations; SHALL use the latched values regardless.

Reset
REQ-027 Reset SHALL force state IDLE and clear the pending slot.
REQ-028 Reset SHALL set jtag_busy, jtag_done, jtag_ovf and ram_we to 0.
REQ-029 Reset SHALL set avs_waitrequest to 1.
REQ-030 Reset SHALL set ram_addr, ram_wdata, jtag_rdata and avs_readdata to 0.
REQ-031 Reset SHALL set last-grant to host.
REQ-032 Reset asserted mid-transaction SHALL abort it with no completion pulse and no RAM write after assertion.

Configuration
REQ-033 Macro COPROCESSOR_DBG_ARB_JTAG_PRIO_EN defined: JTAG SHALL always win contention in IDLE (fixed priority), and the last-grant register SHALL be omitted.
REQ-034 Macro COPROCESSOR_DBG_ARB_JTAG_PRIO_EN undefined: contention SHALL be resolved by round-robin per REQ-021 and REQ-022.

Verification
REQ-035 JTAG write addr 0x10 data 0xDEADBEEF -> ram_we=1, ram_addr=0x10 one cycle after grant; jtag_done in the same cycle.
REQ-036 Host read addr 0x10 with RAM returning 0xDEADBEEF -> avs_waitrequest low and avs_readdata=0xDEADBEEF exactly two cycles after grant.
REQ-037 JTAG and host requests asserted in the same cycle after reset, repeated -> grant order JTAG, host, JTAG, host (round-robin); with the macro defined -> JTAG granted every time.
REQ-038 Second jtag_req while the first is still pending -> second dropped, jtag_ovf=1, exactly one jtag_done.
REQ-039 Reset asserted during RDWAIT of a host read -> next cycle IDLE, avs_waitrequest=1, no jtag_done, ram_we=0.
